// File: rtl/dekatron_counter_if.sv
// Operation/status bundle for the dekatron-style decimal counter.
// The counter drives the slave side; the controller or testbench drives the master side.
interface dekatron_counter_if #(
    parameter int DIGITS = 3
);
    logic                 Request;
    logic                 Reverse;
    logic                 Set;
    logic [DIGITS*10-1:0] In;
    logic [DIGITS*10-1:0] Out;
    logic                 Ready;
    logic                 Zero;
    logic                 Overflow;
    logic                 Error;

    modport master (
        output Request, Reverse, Set, In,
        input  Out, Ready, Zero, Overflow, Error
    );

    modport slave (
        input  Request, Reverse, Set, In,
        output Out, Ready, Zero, Overflow, Error
    );
endinterface

// File: rtl/dekatron_counter.sv
// Cascaded one-hot decimal counter; carries ripple one digit per clock.
// Optional macro DEKATRON_ONEHOT_CHECK_EN: replace non-one-hot load digits with 0 and pulse Error.
//
// state  | meaning
// IDLE   | Ready high, accepts load or count on Request
// RIPPLE | propagating a carry/borrow into digit idx_q
module dekatron_counter #(
    parameter int DIGITS = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    dekatron_counter_if.slave  bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RIPPLE = 1'b1;
    localparam int         W      = DIGITS * 10;
    localparam logic [9:0] POS0   = 10'b0000000001;

    logic [W-1:0] out_q, out_d;
    logic [0:0]   state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         rev_q, rev_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;

    logic [W-1:0] load_val;
    logic         load_bad;
    logic [9:0]   cur, rot;
    logic         dir, wrap;
    logic         zero;

`ifdef DEKATRON_ONEHOT_CHECK_EN
    always_comb begin
        load_val = '0;
        load_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if ($onehot(bus.In[d*10 +: 10])) begin
                load_val[d*10 +: 10] = bus.In[d*10 +: 10];
            end else begin
                load_val[d*10 +: 10] = POS0;
                load_bad             = 1'b1;
            end
        end
    end
`else
    always_comb begin
        load_val = bus.In;
        load_bad = 1'b0;
    end
`endif

    // idx_q is held at 0 in IDLE, so the same digit mux serves both states.
    always_comb begin
        cur     = out_q[int'(idx_q)*10 +: 10];
        dir     = (state_q == IDLE) ? bus.Reverse : rev_q;
        rot     = dir ? {cur[0], cur[9:1]} : {cur[8:0], cur[9]};
        wrap    = dir ? cur[0] : cur[9];
        out_d   = out_q;
        state_d = state_q;
        idx_d   = idx_q;
        rev_d   = rev_q;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Request) begin
                    if (bus.Set) begin
                        out_d = load_val;
                        err_d = load_bad;
                    end else begin
                        out_d[int'(idx_q)*10 +: 10] = rot;
                        rev_d = bus.Reverse;
                        if (wrap) begin
                            if (DIGITS > 1) begin
                                state_d = RIPPLE;
                                idx_d   = 3'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                out_d[int'(idx_q)*10 +: 10] = rot;
                if (wrap && (int'(idx_q) < DIGITS - 1)) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    ovf_d   = wrap;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q   <= {DIGITS{POS0}};
            state_q <= IDLE;
            idx_q   <= 3'd0;
            rev_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rev_q   <= rev_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (out_q[d*10 +: 10] != POS0) zero = 1'b0;
        end
    end

    assign bus.Out      = out_q;
    assign bus.Ready    = (state_q == IDLE);
    assign bus.Zero     = zero;
    assign bus.Overflow = ovf_q;
    assign bus.Error    = err_q;
endmodule

// File: tb/tb_dekatron_counter.sv
// Bench for dekatron_counter (DIGITS=3): vector table, corner sequences, randomized ops vs arithmetic model.
module tb_dekatron_counter;
    localparam int DIGITS = 3;
    localparam int MOD    = 1000;

    logic Clk;
    logic Rst_n;

    dekatron_counter_if #(.DIGITS(DIGITS)) bus ();

    dekatron_counter #(.DIGITS(DIGITS)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit set;
        bit rev;
        int start;
        int arg;
        int exp_val;
        int exp_busy;
        int exp_ovf;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [29:0] enc(input int v);
        logic [29:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*10 + (v / p) % 10] = 1'b1;
            p = p * 10;
        end
        return r;
    endfunction

    // Reference: value arithmetic plus count of digits that roll over.
    function automatic void model(input int v, input bit rev, output int nv,
                                  output int busy, output int ovf);
        int n;
        int t;
        n = 0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            if ((rev && (t % 10 == 0)) || (!rev && (t % 10 == 9))) begin
                n++;
                t = t / 10;
            end else begin
                break;
            end
        end
        nv   = rev ? (v + MOD - 1) % MOD : (v + 1) % MOD;
        busy = (n < DIGITS - 1) ? n : DIGITS - 1;
        ovf  = (n == DIGITS) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_op(input bit set, input bit rev, input logic [29:0] din,
                         output int busy, output int ovf, output int err, output bit to);
        bit done;
        busy = 0;
        ovf  = 0;
        err  = 0;
        done = 0;
        @(negedge Clk);
        bus.Request = 1'b1;
        bus.Set     = set;
        bus.Reverse = rev;
        bus.In      = din;
        @(negedge Clk);
        bus.Request = 1'b0;
        bus.Set     = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (bus.Overflow) ovf++;
            if (bus.Error) err++;
            if (bus.Ready) begin
                done = 1;
                break;
            end
            busy++;
            @(negedge Clk);
        end
        to = !done;
    endtask

    task automatic load(input int v);
        int b, o, e;
        bit t;
        do_op(1'b1, 1'b0, enc(v), b, o, e, t);
        chk("load_out", bus.Out, enc(v));
        chk("load_err", e, 0);
    endtask

    int          busy, ovf, err, nv, ebusy, eovf, cnt, cur;
    bit          to;
    logic [29:0] raw;

    initial begin
        vecs[0] = '{0, 0,   9,   0,  10, 1, 0};
        vecs[1] = '{0, 0, 999,   0,   0, 2, 1};
        vecs[2] = '{0, 1,   0,   0, 999, 2, 1};
        vecs[3] = '{0, 1,  10,   0,   9, 1, 0};
        vecs[4] = '{0, 0, 500,   0, 501, 0, 0};
        vecs[5] = '{0, 1, 123,   0, 122, 0, 0};
        vecs[6] = '{0, 0,  99,   0, 100, 2, 0};
        vecs[7] = '{0, 1, 100,   0,  99, 2, 0};
        vecs[8] = '{1, 0, 123, 555, 555, 0, 0};
        vecs[9] = '{0, 0, 989,   0, 990, 1, 0};

        bus.Request = 1'b0;
        bus.Set     = 1'b0;
        bus.Reverse = 1'b0;
        bus.In      = '0;
        Rst_n       = 1'b1;
        #2 Rst_n    = 1'b0;
        bus.Request = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_out",   bus.Out, enc(0));
        chk("rst_ready", bus.Ready, 1);
        chk("rst_zero",  bus.Zero, 1);
        chk("rst_ovf",   bus.Overflow, 0);
        chk("rst_err",   bus.Error, 0);

        // Request already high at release: first rising edge must count.
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("first_edge_count", bus.Out, enc(1));
        chk("first_edge_zero", bus.Zero, 0);
        @(negedge Clk);
        bus.Request = 1'b0;

        foreach (vecs[i]) begin
            load(vecs[i].start);
            do_op(vecs[i].set, vecs[i].rev, enc(vecs[i].arg), busy, ovf, err, to);
            chk($sformatf("vec%0d_timeout", i), to, 0);
            chk($sformatf("vec%0d_out", i), bus.Out, enc(vecs[i].exp_val));
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_zero", i), bus.Zero, (vecs[i].exp_val == 0) ? 1 : 0);
            chk($sformatf("vec%0d_err", i), err, 0);
        end

        // Load attempted mid-ripple must be dropped.
        load(99);
        @(negedge Clk);
        bus.Request = 1'b1;
        bus.Reverse = 1'b0;
        @(negedge Clk);
        chk("ripple_ready_low", bus.Ready, 0);
        bus.Set = 1'b1;
        bus.In  = enc(555);
        @(negedge Clk);
        bus.Request = 1'b0;
        bus.Set     = 1'b0;
        cnt = 0;
        while (!bus.Ready && cnt < 16) begin
            @(negedge Clk);
            cnt++;
        end
        chk("ignore_timeout", cnt < 16, 1);
        chk("ignore_load_out", bus.Out, enc(100));

        // Reset mid-ripple from 999.
        load(999);
        @(negedge Clk);
        bus.Request = 1'b1;
        bus.Reverse = 1'b0;
        @(negedge Clk);
        bus.Request = 1'b0;
        chk("midrst_busy", bus.Ready, 0);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_out", bus.Out, enc(0));
        chk("midrst_ready", bus.Ready, 1);
        chk("midrst_zero", bus.Zero, 1);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (bus.Overflow) cnt++;
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        if (bus.Overflow) cnt++;
        chk("midrst_no_ovf", cnt, 0);
        chk("midrst_out_after", bus.Out, enc(0));

        // Load with a malformed digit 1.
        raw = enc(703);
        raw[19:10] = 10'b0000000110;
        do_op(1'b1, 1'b0, raw, busy, ovf, err, to);
`ifdef DEKATRON_ONEHOT_CHECK_EN
        chk("bad_load_out", bus.Out, enc(703));
        chk("bad_load_err", err, 1);
`else
        chk("bad_load_out", bus.Out, raw);
        chk("bad_load_err", err, 0);
`endif
        chk("bad_load_busy", busy, 0);

        // Randomized operations against the arithmetic model.
        cur = $urandom_range(0, MOD - 1);
        load(cur);
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                nv = $urandom_range(0, MOD - 1);
                do_op(1'b1, 1'b0, enc(nv), busy, ovf, err, to);
                ebusy = 0;
                eovf  = 0;
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    model(cur, 1'b1, nv, ebusy, eovf);
                    do_op(1'b0, 1'b1, '0, busy, ovf, err, to);
                end else begin
                    model(cur, 1'b0, nv, ebusy, eovf);
                    do_op(1'b0, 1'b0, '0, busy, ovf, err, to);
                end
            end
            chk("rnd_timeout", to, 0);
            chk($sformatf("rnd%0d_out", it), bus.Out, enc(nv));
            chk($sformatf("rnd%0d_busy", it), busy, ebusy);
            chk($sformatf("rnd%0d_ovf", it), ovf, eovf);
            chk($sformatf("rnd%0d_zero", it), bus.Zero, (nv == 0) ? 1 : 0);
            chk($sformatf("rnd%0d_err", it), err, 0);
            cur = nv;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
